// File: rtl/matrix_transpose_stream_if.sv
// matrix_transpose_stream_if: row-in / vector-out stream bundle for the transpose buffer.
// master drives rows and consumes vectors; slave is the transpose buffer itself.
interface matrix_transpose_stream_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_MG = 8,
    parameter int NUM_PE = NUM_MG
);
    logic ctrl;
    logic in_val;
    logic in_rdy;
    logic [NUM_PE-1:0][DATA_WIDTH-1:0] in_row;
    logic out_val;
    logic out_rdy;
    logic [NUM_MG-1:0][DATA_WIDTH-1:0] out_vec;
    logic out_last;
    logic out_tr;
    modport master (
        output ctrl, in_val, in_row, out_rdy,
        input in_rdy, out_val, out_vec, out_last, out_tr
    );
    modport slave (
        input ctrl, in_val, in_row, out_rdy,
        output in_rdy, out_val, out_vec, out_last, out_tr
    );
endinterface

// File: rtl/matrix_transpose_stream.sv
// matrix_transpose_stream: double-buffered streaming transpose, one row in and one
// column (transpose) or row (pass-through) out per beat, with fill/drain overlap.
module matrix_transpose_stream #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_MG = 8,
    parameter int NUM_PE = NUM_MG
) (
    input logic clk,
    input logic rst_n,
    matrix_transpose_stream_if.slave s
);
    localparam int IW = NUM_MG > 1 ? $clog2(NUM_MG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_MG - 1);
    if (NUM_PE != NUM_MG) begin : g_bad_shape
        $error("matrix_transpose_stream: NUM_PE must equal NUM_MG");
    end
    logic [1:0][NUM_MG-1:0][NUM_PE-1:0][DATA_WIDTH-1:0] mem;
    logic [1:0] full;
    logic [1:0] tr;
    logic wr_bank;
    logic rd_bank;
    logic [IW-1:0] wr_row;
    logic [IW-1:0] rd_idx;
    logic wr;
    logic rd;
    logic [NUM_MG-1:0][DATA_WIDTH-1:0] vec;
    assign s.in_rdy = rst_n && !full[wr_bank];
    assign s.out_val = full[rd_bank];
    assign s.out_last = s.out_val && rd_idx == LAST;
    assign s.out_tr = tr[rd_bank];
    assign s.out_vec = vec;
    assign wr = s.in_val && s.in_rdy;
    assign rd = s.out_val && s.out_rdy;
    // storage carries no reset; the full flags alone decide what is visible
    always_ff @(posedge clk)
        if (wr) mem[wr_bank][wr_row] <= s.in_row;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            full <= '0;
            tr <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row <= '0;
            rd_idx <= '0;
        end else begin
            if (wr) begin
                if (wr_row == '0) tr[wr_bank] <= s.ctrl;
                wr_row <= wr_row == LAST ? '0 : wr_row + 1'b1;
                if (wr_row == LAST) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank <= !wr_bank;
                end
            end
            if (rd) begin
                rd_idx <= rd_idx == LAST ? '0 : rd_idx + 1'b1;
                if (rd_idx == LAST) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank <= !rd_bank;
                end
            end
        end
    always_comb
        for (int i = 0; i < NUM_MG; i++)
            vec[i] = !s.out_val ? '0 : s.out_tr ? mem[rd_bank][i][rd_idx] : mem[rd_bank][rd_idx][i];
endmodule

// File: tb/tb_matrix_transpose_stream.sv
// tb_matrix_transpose_stream: directed and randomized checks of the streaming transpose,
// covering reset, orientation, back-to-back flow, backpressure and a scoreboard run.
`timescale 1ns/1ps
module tb_matrix_transpose_stream;
    localparam int W = 64;
    localparam int N = 8;
    typedef logic [N-1:0][W-1:0] vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    matrix_transpose_stream_if #(.DATA_WIDTH(W), .NUM_MG(N), .NUM_PE(N)) ifc ();
    matrix_transpose_stream #(.DATA_WIDTH(W), .NUM_MG(N), .NUM_PE(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s(ifc)
    );
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int stalls = 0;
    vec_t got_vec[$];
    logic got_last[$];
    logic got_tr[$];
    int got_cyc[$];
    int in_cyc[$];
    always @(posedge clk) cyc++;
    // transfers are decided by values stable at the falling edge
    always @(negedge clk)
        if (rst_n) begin
            if (ifc.out_val && ifc.out_rdy) begin
                got_vec.push_back(ifc.out_vec);
                got_last.push_back(ifc.out_last);
                got_tr.push_back(ifc.out_tr);
                got_cyc.push_back(cyc);
            end
            if (ifc.in_val && ifc.in_rdy) in_cyc.push_back(cyc);
        end
    function automatic logic [W-1:0] elem(int base, int r, int c);
        return W'(base + 16 * r + c);
    endfunction
    function automatic vec_t exp_vec(int base, int k, logic t);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = t ? elem(base, i, k) : elem(base, k, i);
        return v;
    endfunction
    task automatic clear_q();
        got_vec.delete();
        got_last.delete();
        got_tr.delete();
        got_cyc.delete();
        in_cyc.delete();
    endtask
    task automatic send_row(vec_t row, logic c);
        logic ok;
        int n;
        ok = 1'b0;
        n = 0;
        ifc.in_val = 1'b1;
        ifc.in_row = row;
        ifc.ctrl = c;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = ifc.in_rdy;
            if (!ok) stalls++;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL in_accept_timeout: row not accepted in %0d cycles, required acceptance", n);
        end
    endtask
    task automatic send_matrix(int base, logic t, int rows, logic drop);
        vec_t row;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < N; c++) row[c] = elem(base, r, c);
            send_row(row, r == 0 ? t : !t);
        end
        if (drop) ifc.in_val = 1'b0;
    endtask
    task automatic wait_beats(int n, int limit);
        for (int i = 0; i < limit && got_vec.size() < n; i++) @(posedge clk);
        #1;
        checks++;
        if (got_vec.size() != n) begin
            fails++;
            $display("FAIL beat_count: got %0d beats, required %0d", got_vec.size(), n);
        end
    endtask
    task automatic check_beats(int first, int base, logic t);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (got_vec[first + k] !== exp_vec(base, k, t) || got_last[first + k] !== (k == N - 1) || got_tr[first + k] !== t) begin
                fails++;
                $display("FAIL beat_%0d: vec=%h last=%b tr=%b, required vec=%h last=%b tr=%b", first + k,
                         got_vec[first + k], got_last[first + k], got_tr[first + k], exp_vec(base, k, t), k == N - 1, t);
            end
        end
    endtask
    task automatic test_reset();
        ifc.in_val = 1'b0;
        ifc.out_rdy = 1'b0;
        ifc.ctrl = 1'b0;
        ifc.in_row = '0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (ifc.in_rdy !== 1'b0 || ifc.out_val !== 1'b0) begin
            fails++;
            $display("FAIL reset_initial: in_rdy=%b out_val=%b, required 0 0", ifc.in_rdy, ifc.out_val);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ifc.in_rdy !== 1'b1 || ifc.out_val !== 1'b0 || ifc.out_last !== 1'b0 || ifc.out_tr !== 1'b0 || ifc.out_vec !== '0) begin
            fails++;
            $display("FAIL reset_idle: in_rdy=%b out_val=%b last=%b tr=%b vec=%h, required 1 0 0 0 0",
                     ifc.in_rdy, ifc.out_val, ifc.out_last, ifc.out_tr, ifc.out_vec);
        end
        send_matrix('h500, 1'b1, N, 1'b0);
        send_matrix('h600, 1'b0, 3, 1'b0);
        checks++;
        if (ifc.out_val !== 1'b1) begin
            fails++;
            $display("FAIL reset_prefill: out_val=%b, required 1", ifc.out_val);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (ifc.out_val !== 1'b0 || ifc.in_rdy !== 1'b0 || ifc.out_vec !== '0) begin
            fails++;
            $display("FAIL reset_midfill: out_val=%b in_rdy=%b vec=%h, required 0 0 0", ifc.out_val, ifc.in_rdy, ifc.out_vec);
        end
        ifc.in_val = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        clear_q();
        @(posedge clk);
        #1;
        checks++;
        if (ifc.in_rdy !== 1'b1 || ifc.out_val !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_rdy=%b out_val=%b, required 1 0", ifc.in_rdy, ifc.out_val);
        end
        ifc.out_rdy = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (got_vec.size() != 0) begin
            fails++;
            $display("FAIL reset_no_stale: %0d beats emitted, required 0", got_vec.size());
        end
    endtask
    task automatic test_orientation(logic t);
        clear_q();
        ifc.out_rdy = 1'b1;
        send_matrix(0, t, N, 1'b1);
        wait_beats(N, 50);
        check_beats(0, 0, t);
        checks++;
        if (got_vec[3][5] !== (t ? 64'd83 : 64'd53)) begin
            fails++;
            $display("FAIL orient_elem_3_5: got %0d, required %0d", got_vec[3][5], t ? 83 : 53);
        end
        checks++;
        if (got_cyc[0] !== in_cyc[N - 1] + 1) begin
            fails++;
            $display("FAIL latency: first out cycle %0d, required %0d", got_cyc[0], in_cyc[N - 1] + 1);
        end
    endtask
    task automatic test_back_to_back();
        int gaps;
        clear_q();
        stalls = 0;
        gaps = 0;
        ifc.out_rdy = 1'b1;
        send_matrix('h100, 1'b1, N, 1'b0);
        send_matrix('h200, 1'b0, N, 1'b0);
        send_matrix('h300, 1'b1, N, 1'b1);
        wait_beats(3 * N, 100);
        checks++;
        if (stalls != 0) begin
            fails++;
            $display("FAIL b2b_in_rdy: %0d stall cycles, required 0", stalls);
        end
        for (int j = 1; j < got_cyc.size(); j++) if (got_cyc[j] != got_cyc[j - 1] + 1) gaps++;
        checks++;
        if (gaps != 0) begin
            fails++;
            $display("FAIL b2b_bubbles: %0d gaps, required 0", gaps);
        end
        check_beats(0, 'h100, 1'b1);
        check_beats(N, 'h200, 1'b0);
        check_beats(2 * N, 'h300, 1'b1);
    endtask
    task automatic test_backpressure();
        vec_t held;
        logic seen;
        clear_q();
        stalls = 0;
        seen = 1'b0;
        ifc.out_rdy = 1'b0;
        send_matrix('h700, 1'b1, N, 1'b0);
        send_matrix('h800, 1'b0, N, 1'b1);
        checks++;
        if (stalls != 0 || ifc.in_rdy !== 1'b0 || ifc.out_val !== 1'b1) begin
            fails++;
            $display("FAIL bp_full: stalls=%0d in_rdy=%b out_val=%b, required 0 0 1", stalls, ifc.in_rdy, ifc.out_val);
        end
        held = ifc.out_vec;
        checks++;
        if (held !== exp_vec('h700, 0, 1'b1)) begin
            fails++;
            $display("FAIL bp_head: vec=%h, required %h", held, exp_vec('h700, 0, 1'b1));
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (ifc.out_vec !== held || ifc.in_rdy !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold: vec=%h in_rdy=%b, required vec=%h in_rdy=0", ifc.out_vec, ifc.in_rdy, held);
        end
        ifc.out_rdy = 1'b1;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = ifc.out_val && ifc.out_last;
        end
        checks++;
        if (!seen || ifc.in_rdy !== 1'b0) begin
            fails++;
            $display("FAIL bp_last_beat: seen=%b in_rdy=%b, required 1 0", seen, ifc.in_rdy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ifc.in_rdy !== 1'b1) begin
            fails++;
            $display("FAIL bp_in_rdy_return: in_rdy=%b, required 1", ifc.in_rdy);
        end
        wait_beats(2 * N, 50);
        check_beats(0, 'h700, 1'b1);
        check_beats(N, 'h800, 1'b0);
    endtask
    task automatic test_random();
        vec_t exp_q[$];
        logic exp_last_q[$];
        logic exp_tr_q[$];
        logic done;
        clear_q();
        done = 1'b0;
        fork
            begin
                for (int m = 0; m < 1000; m++) begin
                    vec_t mat[N];
                    vec_t v;
                    logic t;
                    t = 1'($urandom_range(0, 1));
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++) mat[r][c] = {$urandom, $urandom};
                    for (int k = 0; k < N; k++) begin
                        for (int i = 0; i < N; i++) v[i] = t ? mat[i][k] : mat[k][i];
                        exp_q.push_back(v);
                        exp_last_q.push_back(k == N - 1);
                        exp_tr_q.push_back(t);
                    end
                    for (int r = 0; r < N; r++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            ifc.in_val = 1'b0;
                            @(posedge clk);
                            #1;
                        end
                        send_row(mat[r], r == 0 ? t : 1'($urandom_range(0, 1)));
                    end
                end
                ifc.in_val = 1'b0;
                wait_beats(exp_q.size(), 5000);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ifc.out_rdy = $urandom_range(0, 3) != 0;
                end
            end
        join
        for (int j = 0; j < exp_q.size() && j < got_vec.size(); j++) begin
            checks++;
            if (got_vec[j] !== exp_q[j] || got_last[j] !== exp_last_q[j] || got_tr[j] !== exp_tr_q[j]) begin
                fails++;
                $display("FAIL rand_beat_%0d: vec=%h last=%b tr=%b, required vec=%h last=%b tr=%b", j,
                         got_vec[j], got_last[j], got_tr[j], exp_q[j], exp_last_q[j], exp_tr_q[j]);
            end
        end
    endtask
    initial begin
        test_reset();
        test_orientation(1'b1);
        test_orientation(1'b0);
        test_back_to_back();
        test_backpressure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
